// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with same-cycle write bypass,
// one synchronous write port, r0 hardwired to zero, and a committed-write counter.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rf_ra1,
  input  logic [ADDR_W-1:0] rf_ra2,
  output logic [DATA_W-1:0] rf_rd1,
  output logic [DATA_W-1:0] rf_rd2,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_wa,
  input  logic [DATA_W-1:0] rf_wd,
  output logic [15:0]       rf_wcnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Flop array rather than RAM so the asynchronous reset can clear every entry.
  logic [DATA_W-1:0] regs_q [Depth];
  logic [15:0]       wcnt_q;
  logic              wr_en;

  // Writes to r0 are dropped; reset masks the bypass path as well.
  always_comb begin
    wr_en = rst & rf_we & (rf_wa != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      wcnt_q <= '0;
    end else if (wr_en) begin
      regs_q[rf_wa] <= rf_wd;
      wcnt_q        <= wcnt_q + 16'd1;
    end
  end

  // Bypass and zero forcing sit after the array mux.
  always_comb begin
    rf_rd1 = regs_q[rf_ra1];
    if (wr_en && (rf_wa == rf_ra1)) begin
      rf_rd1 = rf_wd;
    end
    if (!rst || (rf_ra1 == '0)) begin
      rf_rd1 = '0;
    end
  end

  always_comb begin
    rf_rd2 = regs_q[rf_ra2];
    if (wr_en && (rf_wa == rf_ra2)) begin
      rf_rd2 = rf_wd;
    end
    if (!rst || (rf_ra2 == '0)) begin
      rf_rd2 = '0;
    end
  end

  always_comb begin
    rf_wcnt = wcnt_q;
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read/counter values,
// a monitor process pops and compares them against the live DUT outputs.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [15:0] rf_wcnt;

  reg_file #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rf_ra1 (rf_ra1),
    .rf_ra2 (rf_ra2),
    .rf_rd1 (rf_rd1),
    .rf_rd2 (rf_rd2),
    .rf_we  (rf_we),
    .rf_wa  (rf_wa),
    .rf_wd  (rf_wd),
    .rf_wcnt(rf_wcnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  mask;  // bit0 rd1, bit1 rd2, bit2 wcnt
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic check_req = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: consumes every queued expectation when the stimulus presents a sample point.
  initial begin
    exp_t e;
    forever begin
      @(check_req);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.mask[0]) begin
          total++;
          if (rf_rd1 !== e.e1) begin
            bad++;
            $display("FAIL %s rd1: got %h want %h", e.name, rf_rd1, e.e1);
          end
        end
        if (e.mask[1]) begin
          total++;
          if (rf_rd2 !== e.e2) begin
            bad++;
            $display("FAIL %s rd2: got %h want %h", e.name, rf_rd2, e.e2);
          end
        end
        if (e.mask[2]) begin
          total++;
          if (rf_wcnt !== e.ec) begin
            bad++;
            $display("FAIL %s wcnt: got %h want %h", e.name, rf_wcnt, e.ec);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [2:0] m, input logic [31:0] a,
                     input logic [31:0] b, input logic [15:0] c);
    exp_t e;
    e.name = nm;
    e.mask = m;
    e.e1   = a;
    e.e2   = b;
    e.ec   = c;
    exp_q.push_back(e);
    check_req = ~check_req;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset, with a write pending to r5 that must be ignored
    rst = 1'b0;
    rf_ra1 = 5'd5;
    rf_ra2 = 5'd31;
    rf_we = 1'b1;
    rf_wa = 5'd5;
    rf_wd = 32'h0000_0099;
    #2;
    chk("reset_hold", 3'b111, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_after_edges", 3'b111, 32'h0, 32'h0, 16'h0);
    rst = 1'b1;
    rf_we = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rf_ra1 = 5'(i);
      rf_ra2 = 5'(31 - i);
      chk("read_all_zero", 3'b011, 32'h0, 32'h0, 16'h0);
    end
    chk("wcnt_post_reset", 3'b100, 32'h0, 32'h0, 16'h0);

    // 2: write then read back
    rf_we = 1'b1;
    rf_wa = 5'd7;
    rf_wd = 32'hDEAD_BEEF;
    cyc();
    rf_wa = 5'd31;
    rf_wd = 32'h1234_5678;
    cyc();
    rf_we = 1'b0;
    rf_ra1 = 5'd7;
    rf_ra2 = 5'd31;
    chk("readback", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 16'd2);

    // 3: r0 protection
    rf_we = 1'b1;
    rf_wa = 5'd0;
    rf_wd = 32'hFFFF_FFFF;
    rf_ra1 = 5'd0;
    rf_ra2 = 5'd0;
    chk("r0_bypass", 3'b111, 32'h0, 32'h0, 16'd2);
    cyc();
    rf_we = 1'b0;
    chk("r0_after", 3'b111, 32'h0, 32'h0, 16'd2);

    // 4: bypass
    rf_we = 1'b1;
    rf_wa = 5'd3;
    rf_wd = 32'h0000_0011;
    cyc();
    rf_wd = 32'h0000_0022;
    rf_ra1 = 5'd3;
    rf_ra2 = 5'd3;
    chk("bypass_both", 3'b111, 32'h22, 32'h22, 16'd3);
    cyc();
    rf_we = 1'b0;
    chk("bypass_stored", 3'b111, 32'h22, 32'h22, 16'd4);
    rf_we = 1'b1;
    rf_wa = 5'd7;
    rf_wd = 32'h0000_0077;
    rf_ra2 = 5'd7;
    chk("bypass_port2_only", 3'b011, 32'h22, 32'h77, 16'd4);
    cyc();
    rf_we = 1'b0;
    chk("port2_stored", 3'b111, 32'h22, 32'h77, 16'd5);

    // 5: asynchronous reset between edges
    rf_we = 1'b1;
    rf_wa = 5'd10;
    rf_wd = 32'hA5A5_A5A5;
    cyc();
    rf_we = 1'b0;
    rf_ra1 = 5'd10;
    chk("r10_written", 3'b101, 32'hA5A5_A5A5, 32'h0, 16'd6);
    rf_we = 1'b1;
    rf_wd = 32'h0000_5555;
    chk("r10_bypass_pre_reset", 3'b001, 32'h5555, 32'h0, 16'd6);
    rst = 1'b0;
    #1;
    chk("async_reset_drop", 3'b111, 32'h0, 32'h0, 16'd0);
    rst = 1'b1;
    rf_we = 1'b0;
    cyc();
    chk("after_async_reset", 3'b111, 32'h0, 32'h0, 16'd0);

    // 6: counter wrap
    rf_we = 1'b1;
    rf_wa = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      rf_wd = 32'(i);
      cyc();
    end
    rf_we = 1'b0;
    rf_ra1 = 5'd1;
    chk("wcnt_max", 3'b101, 32'h0000_FFFE, 32'h0, 16'hFFFF);
    rf_we = 1'b1;
    rf_wd = 32'h0000_FFFF;
    cyc();
    rf_we = 1'b0;
    chk("wcnt_wrap", 3'b101, 32'h0000_FFFF, 32'h0, 16'h0000);

    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
